// File: rtl/sha_pipelined_nonce_scheduler.sv
// Nonce scheduler for one fully pipelined double-SHA256 core: issues this processor's
// interleaved nonce slice, tracks every slot through the core latency and reports hits.
module sha_pipelined_nonce_scheduler #(
    parameter int unsigned PROCESSORINDEX = 0,
    parameter int unsigned NUMPROCESSORS  = 1,
    parameter int unsigned LATENCY        = 130,
    parameter int unsigned NONCE_BITS     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_tail,
    input  logic [5:0]   work_zerobits,
    output logic         core_newblock,
    output logic         core_valid,
    output logic [31:0]  core_nonce,
    output logic [255:0] core_hashstate,
    output logic [95:0]  core_tail,
    input  logic [31:0]  core_h7,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic         busy,
    output logic         done,
    output logic [7:0]   dropped_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DRAIN} state_e;

    // 33-bit nonce arithmetic keeps the end-of-slice test free of wraparound.
    localparam logic [32:0] NONCE_END   = 33'd1 << NONCE_BITS;
    localparam logic [32:0] NONCE_FIRST = 33'(PROCESSORINDEX);
    localparam logic [32:0] NONCE_STEP  = 33'(NUMPROCESSORS);

    state_e         state_q, state_d;
    logic [32:0]    nonce_q, nonce_d;
    logic           epoch_q, epoch_d;
    logic [255:0]   mid_q;
    logic [95:0]    tail_q;
    logic [5:0]     zbits_q;
    logic [LATENCY-1:0] tag_v_q;
    logic [LATENCY-1:0] tag_e_q;
    logic [31:0]    tag_n_q [LATENCY];
    logic           found_valid_q;
    logic [31:0]    found_nonce_q;
    logic [7:0]     drop_q;

    logic           accept;
    logic           in_flight;
    logic           last_issue;
    logic           drain_done;
    logic           hit;
    logic [32:0]    nonce_nxt;
    logic [5:0]     shamt;

    // Handshake: a work unit transfers in any cycle where work_valid and work_ready
    // are both high; a hit transfers when found_valid and found_ready are both high.
    assign work_ready = rst & (state_q != ST_LOAD);
    assign accept     = work_valid & work_ready;
    assign nonce_nxt  = nonce_q + NONCE_STEP;
    assign last_issue = (nonce_nxt >= NONCE_END);

    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            if (tag_v_q[i] && (tag_e_q[i] == epoch_q)) in_flight = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        nonce_d    = nonce_q;
        epoch_d    = epoch_q;
        drain_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                nonce_d = NONCE_FIRST;
            end
            ST_RUN: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    epoch_d = ~epoch_q;
                end else if (last_issue) begin
                    state_d = ST_DRAIN;
                end else begin
                    nonce_d = nonce_nxt;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    epoch_d = ~epoch_q;
                end else if (!in_flight) begin
                    state_d    = ST_IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            nonce_q <= '0;
            epoch_q <= 1'b0;
            mid_q   <= '0;
            tail_q  <= '0;
            zbits_q <= '0;
        end else begin
            state_q <= state_d;
            nonce_q <= nonce_d;
            epoch_q <= epoch_d;
            if (accept) begin
                mid_q   <= work_midstate;
                tail_q  <= work_tail;
                zbits_q <= work_zerobits;
            end
        end
    end

    // Slot tags travel alongside the core so the exiting tag lines up with core_h7.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v_q <= '0;
            tag_e_q <= '0;
            for (int i = 0; i < LATENCY; i++) tag_n_q[i] <= '0;
        end else begin
            tag_v_q[0] <= core_valid;
            tag_e_q[0] <= epoch_q;
            tag_n_q[0] <= core_nonce;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_e_q[i] <= tag_e_q[i-1];
                tag_n_q[i] <= tag_n_q[i-1];
            end
        end
    end

    assign shamt = 6'd32 - zbits_q;
    assign hit   = tag_v_q[LATENCY-1] && (tag_e_q[LATENCY-1] == epoch_q)
                   && ((core_h7 >> shamt) == 32'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            found_valid_q <= 1'b0;
            found_nonce_q <= '0;
            drop_q        <= '0;
        end else begin
            if (hit && (!found_valid_q || found_ready)) begin
                found_valid_q <= 1'b1;
                found_nonce_q <= tag_n_q[LATENCY-1];
            end else if (found_ready) begin
                found_valid_q <= 1'b0;
            end
            if (hit && found_valid_q && !found_ready && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign core_newblock  = (state_q == ST_LOAD);
    assign core_valid     = (state_q == ST_RUN);
    assign core_nonce     = nonce_q[31:0];
    assign core_hashstate = mid_q;
    assign core_tail      = tail_q;
    assign found_valid    = found_valid_q;
    assign found_nonce    = found_nonce_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = drain_done;
    assign dropped_count  = drop_q;

endmodule

// File: tb/tb_sha_pipelined_nonce_scheduler.sv
// Bench for sha_pipelined_nonce_scheduler: a table-driven core model feeds core_h7 and
// a slot-level reference model predicts issued nonces, hits, done and drop counts.
module tb_sha_pipelined_nonce_scheduler;
  localparam int LAT = 8;
  localparam int NB  = 4;
  localparam int INF = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         work_valid = 1'b0, work_valid2 = 1'b0;
  logic [255:0] work_midstate = '0;
  logic [95:0]  work_tail = '0;
  logic [5:0]   work_zerobits = '0;
  logic [31:0]  core_h7 = '0;
  logic [31:0]  core_h7_2 = 32'hFFFF_FFFF;
  logic         found_ready = 1'b0;
  logic         found_ready2 = 1'b1;

  logic         work_ready, core_newblock, core_valid, found_valid, busy, done;
  logic [31:0]  core_nonce, found_nonce;
  logic [255:0] core_hashstate;
  logic [95:0]  core_tail;
  logic [7:0]   dropped_count;
  logic         work_ready2, core_newblock2, core_valid2, found_valid2, busy2, done2;
  logic [31:0]  core_nonce2, found_nonce2;
  logic [255:0] core_hashstate2;
  logic [95:0]  core_tail2;
  logic [7:0]   dropped_count2;

  sha_pipelined_nonce_scheduler #(.PROCESSORINDEX(0), .NUMPROCESSORS(1), .LATENCY(LAT),
    .NONCE_BITS(NB)) u_dut (
    .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_tail(work_tail), .work_zerobits(work_zerobits),
    .core_newblock(core_newblock), .core_valid(core_valid), .core_nonce(core_nonce),
    .core_hashstate(core_hashstate), .core_tail(core_tail), .core_h7(core_h7),
    .found_valid(found_valid), .found_ready(found_ready), .found_nonce(found_nonce),
    .busy(busy), .done(done), .dropped_count(dropped_count));

  sha_pipelined_nonce_scheduler #(.PROCESSORINDEX(2), .NUMPROCESSORS(3), .LATENCY(LAT),
    .NONCE_BITS(NB)) u_dut2 (
    .clk(clk), .rst(rst), .work_valid(work_valid2), .work_ready(work_ready2),
    .work_midstate(work_midstate), .work_tail(work_tail), .work_zerobits(work_zerobits),
    .core_newblock(core_newblock2), .core_valid(core_valid2), .core_nonce(core_nonce2),
    .core_hashstate(core_hashstate2), .core_tail(core_tail2), .core_h7(core_h7_2),
    .found_valid(found_valid2), .found_ready(found_ready2), .found_nonce(found_nonce2),
    .busy(busy2), .done(done2), .dropped_count(dropped_count2));

  int checks = 0;
  int errors = 0;

  // Core model: hash result of a slot appears LAT cycles after issue; idle slots return 0.
  logic [31:0] h7_tab [16];
  logic [32:0] hist [$];
  always @(negedge clk) begin
    hist.push_back({core_valid, core_nonce});
    if (hist.size() > LAT + 1) void'(hist.pop_front());
    if (hist.size() == LAT + 1 && hist[0][32]) core_h7 = h7_tab[hist[0][3:0]];
    else core_h7 = 32'h0;
  end

  // Observed event logs.
  logic [31:0] iss_n [$], fnd_n [$], iss2_n [$];
  int iss_c [$], nb_c [$], done_c [$], fnd_c [$], iss2_c [$], done2_c [$];
  always @(negedge clk) begin
    if (rst) begin
      if (core_valid) begin iss_n.push_back(core_nonce); iss_c.push_back(cyc); end
      if (core_newblock) nb_c.push_back(cyc);
      if (done) done_c.push_back(cyc);
      if (found_valid && found_ready) begin fnd_n.push_back(found_nonce); fnd_c.push_back(cyc); end
      if (core_valid2) begin iss2_n.push_back(core_nonce2); iss2_c.push_back(cyc); end
      if (done2) done2_c.push_back(cyc);
    end
  end

  // Scoreboard expectations.
  logic [31:0]  exp_q [$], exp_found_q [$];
  int           exp_c [$], exp_found_c [$];
  logic [255:0] exp_mid;
  logic [95:0]  exp_tail;

  function automatic int lead_zeros(input logic [31:0] v);
    int n = 0;
    for (int b = 31; b >= 0; b--) begin
      if (v[b]) break;
      n++;
    end
    return n;
  endfunction

  // Slot k of a unit accepted at t0 goes out at t0+2+k; a hit is visible one cycle after
  // its hash returns, and only if the unit was still current when the hash returned.
  task automatic add_unit(input int pi, input int np, input int zb, input int t0,
                          input int last_issue_c, input int last_exit_c);
    int k, n, ic;
    k = 0;
    while (pi + k * np < (1 << NB)) begin
      n = pi + k * np;
      ic = t0 + 2 + k;
      if (ic <= last_issue_c) begin
        exp_q.push_back(32'(n));
        exp_c.push_back(ic);
        if (lead_zeros(h7_tab[n]) >= zb && ic + LAT <= last_exit_c) begin
          exp_found_q.push_back(32'(n));
          exp_found_c.push_back(ic + LAT + 1);
        end
      end
      k++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    iss_n.delete(); iss_c.delete(); nb_c.delete(); done_c.delete();
    fnd_n.delete(); fnd_c.delete(); iss2_n.delete(); iss2_c.delete(); done2_c.delete();
    exp_q.delete(); exp_c.delete(); exp_found_q.delete(); exp_found_c.delete();
  endtask

  task automatic do_reset();
    work_valid = 1'b0;
    work_valid2 = 1'b0;
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    step();
  endtask

  task automatic send_work(input logic [5:0] zb, input bit second, output int t);
    step();
    for (int i = 0; i < 8; i++) work_midstate[i*32 +: 32] = $urandom();
    for (int i = 0; i < 3; i++) work_tail[i*32 +: 32] = $urandom();
    work_zerobits = zb;
    exp_mid = work_midstate;
    exp_tail = work_tail;
    if (second) work_valid2 = 1'b1; else work_valid = 1'b1;
    t = cyc;
    step();
    work_valid = 1'b0;
    work_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({work_ready, core_newblock, core_valid, found_valid, busy, done} !== 6'b0 ||
        core_nonce !== 32'd0 || found_nonce !== 32'd0 || dropped_count !== 8'd0 ||
        core_hashstate !== 256'd0 || core_tail !== 96'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b busy=%b cv=%b fv=%b drop=%0d, want all 0",
               work_ready, busy, core_valid, found_valid, dropped_count);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if (work_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b, want ready=1 busy=0", work_ready, busy);
    end
  endtask

  task automatic test_unit(input string name, input int mode, input int zb);
    int t0;
    for (int i = 0; i < 16; i++) begin
      if (mode == 0) h7_tab[i] = 32'hFFFF_FFFF;
      else if (mode == 1) h7_tab[i] = (i == 7) ? 32'h0000_0FFF : 32'hFFFF_FFFF;
      else h7_tab[i] = $urandom() >> $urandom_range(0, 10);
    end
    found_ready = 1'b1;
    clear_logs();
    send_work(6'(zb), 1'b0, t0);
    add_unit(0, 1, zb, t0, INF, INF);
    idle(40);
    checks++;
    if (iss_n.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s issue_count: got %0d want %0d", name, iss_n.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < iss_n.size(); i++) begin
      checks++;
      if (iss_n[i] !== exp_q[i] || iss_c[i] !== exp_c[i]) begin
        errors++;
        $display("FAIL %s issue[%0d]: got nonce %0d @%0d want %0d @%0d", name, i,
                 iss_n[i], iss_c[i], exp_q[i], exp_c[i]);
      end
    end
    checks++;
    if (nb_c.size() != 1 || nb_c[0] != t0 + 1) begin
      errors++;
      $display("FAIL %s newblock: got %0d pulses first @%0d want 1 @%0d", name, nb_c.size(),
               (nb_c.size() > 0) ? nb_c[0] : -1, t0 + 1);
    end
    checks++;
    if (done_c.size() != 1 || done_c[0] != exp_c[$] + LAT + 1) begin
      errors++;
      $display("FAIL %s done: got %0d pulses first @%0d want 1 @%0d", name, done_c.size(),
               (done_c.size() > 0) ? done_c[0] : -1, exp_c[$] + LAT + 1);
    end
    checks++;
    if (fnd_n.size() != exp_found_q.size()) begin
      errors++;
      $display("FAIL %s found_count: got %0d want %0d", name, fnd_n.size(), exp_found_q.size());
    end
    for (int i = 0; i < exp_found_q.size() && i < fnd_n.size(); i++) begin
      checks++;
      if (fnd_n[i] !== exp_found_q[i] || fnd_c[i] !== exp_found_c[i]) begin
        errors++;
        $display("FAIL %s found[%0d]: got %0d @%0d want %0d @%0d", name, i, fnd_n[i],
                 fnd_c[i], exp_found_q[i], exp_found_c[i]);
      end
    end
    checks++;
    if (core_hashstate !== exp_mid || core_tail !== exp_tail || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s capture: hash=%h tail=%h busy=%b want hash=%h tail=%h busy=0", name,
               core_hashstate[31:0], core_tail[31:0], busy, exp_mid[31:0], exp_tail[31:0]);
    end
  endtask

  task automatic test_stride();
    int t0;
    clear_logs();
    send_work(6'd8, 1'b1, t0);
    add_unit(2, 3, 33, t0, INF, INF);
    idle(40);
    checks++;
    if (iss2_n.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stride issue_count: got %0d want %0d", iss2_n.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < iss2_n.size(); i++) begin
      checks++;
      if (iss2_n[i] !== exp_q[i] || iss2_c[i] !== exp_c[i]) begin
        errors++;
        $display("FAIL stride issue[%0d]: got %0d @%0d want %0d @%0d", i, iss2_n[i],
                 iss2_c[i], exp_q[i], exp_c[i]);
      end
    end
    checks++;
    if (done2_c.size() != 1 || done2_c[0] != exp_c[$] + LAT + 1) begin
      errors++;
      $display("FAIL stride done: got %0d pulses want 1 @%0d", done2_c.size(), exp_c[$] + LAT + 1);
    end
  endtask

  task automatic test_backpressure();
    int t0;
    do_reset();
    for (int i = 0; i < 16; i++) h7_tab[i] = (i == 3 || i == 4) ? 32'h0 : 32'hFFFF_FFFF;
    found_ready = 1'b0;
    clear_logs();
    send_work(6'd8, 1'b0, t0);
    add_unit(0, 1, 8, t0, INF, INF);
    idle(40);
    checks++;
    if (found_valid !== 1'b1 || found_nonce !== exp_found_q[0] || fnd_n.size() != 0) begin
      errors++;
      $display("FAIL backpressure_hold: valid=%b nonce=%0d taken=%0d want valid=1 nonce=%0d taken=0",
               found_valid, found_nonce, fnd_n.size(), exp_found_q[0]);
    end
    checks++;
    if (dropped_count !== 8'(exp_found_q.size() - 1)) begin
      errors++;
      $display("FAIL backpressure_drop: got %0d want %0d", dropped_count, exp_found_q.size() - 1);
    end
    found_ready = 1'b1;
    step();
    found_ready = 1'b0;
    checks++;
    if (found_valid !== 1'b0 || fnd_n.size() != 1 || fnd_n[0] !== exp_found_q[0]) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b taken=%0d want valid=0 taken=1 nonce=%0d",
               found_valid, fnd_n.size(), exp_found_q[0]);
    end
  endtask

  task automatic test_drop_saturate();
    int t0, total;
    do_reset();
    for (int i = 0; i < 16; i++) h7_tab[i] = 32'h0;
    found_ready = 1'b0;
    total = 0;
    for (int u = 1; u <= 18; u++) begin
      clear_logs();
      send_work(6'd32, 1'b0, t0);
      add_unit(0, 1, 32, t0, INF, INF);
      total += exp_found_q.size();
      idle(30);
      checks++;
      if (dropped_count !== 8'((total - 1 > 255) ? 255 : total - 1)) begin
        errors++;
        $display("FAIL drop_saturate unit %0d: got %0d want %0d", u, dropped_count,
                 (total - 1 > 255) ? 255 : total - 1);
      end
    end
    checks++;
    if (found_valid !== 1'b1 || found_nonce !== 32'd0) begin
      errors++;
      $display("FAIL drop_saturate_hold: valid=%b nonce=%0d want valid=1 nonce=0",
               found_valid, found_nonce);
    end
  endtask

  task automatic test_abort(input string name, input int at);
    int t0, t1;
    for (int i = 0; i < 16; i++) h7_tab[i] = (i == 5) ? 32'h0 : 32'hFFFF_FFFF;
    found_ready = 1'b1;
    clear_logs();
    send_work(6'd1, 1'b0, t0);
    idle(at - 2);
    send_work(6'd1, 1'b0, t1);
    add_unit(0, 1, 1, t0, t1, t1);
    add_unit(0, 1, 1, t1, INF, INF);
    idle(40);
    checks++;
    if (iss_n.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s issue_count: got %0d want %0d", name, iss_n.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < iss_n.size(); i++) begin
      checks++;
      if (iss_n[i] !== exp_q[i] || iss_c[i] !== exp_c[i]) begin
        errors++;
        $display("FAIL %s issue[%0d]: got %0d @%0d want %0d @%0d", name, i, iss_n[i],
                 iss_c[i], exp_q[i], exp_c[i]);
      end
    end
    checks++;
    if (nb_c.size() != 2 || nb_c[0] != t0 + 1 || nb_c[1] != t1 + 1) begin
      errors++;
      $display("FAIL %s newblock: got %0d pulses want 2 @%0d,%0d", name, nb_c.size(),
               t0 + 1, t1 + 1);
    end
    checks++;
    if (done_c.size() != 1 || done_c[0] != exp_c[$] + LAT + 1) begin
      errors++;
      $display("FAIL %s done: got %0d pulses first @%0d want 1 @%0d", name, done_c.size(),
               (done_c.size() > 0) ? done_c[0] : -1, exp_c[$] + LAT + 1);
    end
    checks++;
    if (fnd_n.size() != exp_found_q.size()) begin
      errors++;
      $display("FAIL %s found_count: got %0d want %0d", name, fnd_n.size(), exp_found_q.size());
    end
    for (int i = 0; i < exp_found_q.size() && i < fnd_n.size(); i++) begin
      checks++;
      if (fnd_n[i] !== exp_found_q[i] || fnd_c[i] !== exp_found_c[i]) begin
        errors++;
        $display("FAIL %s found[%0d]: got %0d @%0d want %0d @%0d", name, i, fnd_n[i],
                 fnd_c[i], exp_found_q[i], exp_found_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int t0;
    do_reset();
    for (int i = 0; i < 16; i++) h7_tab[i] = (i < 2) ? 32'h0 : 32'hFFFF_FFFF;
    found_ready = 1'b0;
    clear_logs();
    send_work(6'd16, 1'b0, t0);
    idle(12);
    checks++;
    if (core_valid !== 1'b1 || found_valid !== 1'b1 || dropped_count !== 8'd1) begin
      errors++;
      $display("FAIL midrun_pre: cv=%b fv=%b drop=%0d want cv=1 fv=1 drop=1",
               core_valid, found_valid, dropped_count);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({work_ready, core_newblock, core_valid, found_valid, busy, done} !== 6'b0 ||
        core_nonce !== 32'd0 || found_nonce !== 32'd0 || dropped_count !== 8'd0 ||
        core_hashstate !== 256'd0 || core_tail !== 96'd0) begin
      errors++;
      $display("FAIL midrun_async_clear: ready=%b cv=%b fv=%b busy=%b drop=%0d want all 0",
               work_ready, core_valid, found_valid, busy, dropped_count);
    end
    idle(2);
    rst = 1'b1;
    #1;
    checks++;
    if (work_ready !== 1'b1 || busy !== 1'b0 || found_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: ready=%b busy=%b fv=%b want 1,0,0", work_ready, busy, found_valid);
    end
    idle(5);
    checks++;
    if (core_valid !== 1'b0 || busy !== 1'b0 || done_c.size() != 0) begin
      errors++;
      $display("FAIL midrun_idle: cv=%b busy=%b dones=%0d want 0,0,0", core_valid, busy, done_c.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) h7_tab[i] = 32'hFFFF_FFFF;
    #2 rst = 1'b0;
    test_reset();
    test_unit("sweep", 0, 20);
    test_unit("hit7_zb20", 1, 20);
    test_unit("hit7_zb21", 1, 21);
    for (int r = 0; r < 3; r++) test_unit("random", 2, $urandom_range(1, 8));
    test_unit("random_zb1", 2, 1);
    test_stride();
    test_abort("abort_mid", 10);
    test_abort("abort_last", 17);
    test_backpressure();
    test_drop_saturate();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
